// File: rtl/full_adder_tgl_seq.sv
// Bit-serial sequencer driving one two-phase dual-rail full adder, LSB first.
// Optional WAIT-state watchdog enabled by defining FA_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module full_adder_tgl_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_err,
  output logic             fa_rst,
  output logic [1:0]       fa_a,
  output logic [1:0]       fa_b,
  output logic [1:0]       fa_cin,
  input  logic [1:0]       fa_s,
  input  logic [1:0]       fa_cout
);

  localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntMax = (TIMEOUT > SYNC_STAGES) ? TIMEOUT : SYNC_STAGES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(WIDTH - 1);
  localparam logic [CntW-1:0] FlushLast = CntW'(SYNC_STAGES);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StFlush} state_e;

  state_e           r_state;
  logic             r_in_ready, r_out_valid, r_out_cout, r_out_err, r_fa_rst;
  logic [WIDTH-1:0] r_out_sum, r_a, r_b, r_acc;
  logic [1:0]       r_fa_a, r_fa_b, r_fa_cin, r_s_ref, r_c_ref;
  logic             r_carry;
  logic [IdxW-1:0]  r_idx;
  logic [CntW-1:0]  r_cnt;
  logic [1:0]       r_s_sync [SYNC_STAGES];
  logic [1:0]       r_c_sync [SYNC_STAGES];

  logic [1:0]       w_s_new, w_c_new, w_s_diff, w_c_diff;
  logic             w_s_one, w_c_one, w_go_flush, w_timeout;
  logic [1:0]       w_a_tgl, w_b_tgl, w_cin_tgl;
  logic [WIDTH-1:0] w_acc_next;

  // Adder outputs are asynchronous; plain multi-flop synchronisers per rail pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_s_sync[i] <= 2'b00;
        r_c_sync[i] <= 2'b00;
      end
    end else begin
      r_s_sync[0] <= fa_s;
      r_c_sync[0] <= fa_cout;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_s_sync[i] <= r_s_sync[i-1];
        r_c_sync[i] <= r_c_sync[i-1];
      end
    end
  end

  assign w_s_new  = r_s_sync[SYNC_STAGES-1];
  assign w_c_new  = r_c_sync[SYNC_STAGES-1];
  assign w_s_diff = w_s_new ^ r_s_ref;
  assign w_c_diff = w_c_new ^ r_c_ref;
  assign w_s_one  = ^w_s_diff;
  assign w_c_one  = ^w_c_diff;

`ifdef FA_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT);
  assign w_timeout = (r_cnt == TimeoutLast);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_go_flush = (&w_s_diff) || (&w_c_diff) || (w_timeout && !(w_s_one && w_c_one));

  // Value v is encoded by toggling rail[v].
  assign w_a_tgl   = r_a[r_idx] ? 2'b10 : 2'b01;
  assign w_b_tgl   = r_b[r_idx] ? 2'b10 : 2'b01;
  assign w_cin_tgl = r_carry    ? 2'b10 : 2'b01;

  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[r_idx] = w_s_diff[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_err   <= 1'b0;
      r_fa_rst    <= 1'b1;
      r_fa_a      <= 2'b00;
      r_fa_b      <= 2'b00;
      r_fa_cin    <= 2'b00;
      r_s_ref     <= 2'b00;
      r_c_ref     <= 2'b00;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
    end else begin
      r_fa_rst <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_carry    <= in_cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_fa_a   <= r_fa_a ^ w_a_tgl;
          r_fa_b   <= r_fa_b ^ w_b_tgl;
          r_fa_cin <= r_fa_cin ^ w_cin_tgl;
          r_cnt    <= '0;
          r_state  <= StWait;
        end
        StWait: begin
          if (w_go_flush) begin
            r_fa_rst <= 1'b1;
            r_fa_a   <= 2'b00;
            r_fa_b   <= 2'b00;
            r_fa_cin <= 2'b00;
            r_s_ref  <= 2'b00;
            r_c_ref  <= 2'b00;
            r_cnt    <= '0;
            r_state  <= StFlush;
          end else if (w_s_one && w_c_one) begin
            r_acc   <= w_acc_next;
            r_carry <= w_c_diff[1];
            r_s_ref <= w_s_new;
            r_c_ref <= w_c_new;
            if (r_idx == LastIdx) begin
              r_out_sum   <= w_acc_next;
              r_out_cout  <= w_c_diff[1];
              r_out_err   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_idx   <= r_idx + IdxW'(1);
              r_state <= StIssue;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StFlush: begin
          if (r_cnt == FlushLast) begin
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_fa_rst <= 1'b1;
            r_cnt    <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_err   = r_out_err;
  assign fa_rst    = r_fa_rst;
  assign fa_a      = r_fa_a;
  assign fa_b      = r_fa_b;
  assign fa_cin    = r_fa_cin;

endmodule

// File: tb/tb_full_adder_tgl_seq.sv
// Directed bench for full_adder_tgl_seq with a behavioural two-phase dual-rail adder model.
`timescale 1ns/1ps
module tb_full_adder_tgl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_cout, out_err, fa_rst;
  logic [1:0] fa_a, fa_b, fa_cin;
  logic [1:0] fa_s = 2'b00;
  logic [1:0] fa_cout = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  full_adder_tgl_seq #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
    .fa_rst(fa_rst), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_s(fa_s), .fa_cout(fa_cout)
  );

  always #50 clk = ~clk;

  // Adder model: a token is complete when every input pair has exactly one toggled rail.
  logic [1:0] m_a_ref = 2'b00, m_b_ref = 2'b00, m_c_ref = 2'b00;
  int         m_tok = 0;
  int         m_bad_tok = -1;
  bit         m_bad_en = 1'b0;
  bit         m_mute = 1'b0;
  logic       m_va, m_vb, m_vc;
  logic [1:0] m_st, m_ct;
  int         m_ds, m_dc;

  always @(negedge clk) begin
    if (fa_rst === 1'b1) begin
      m_a_ref = 2'b00; m_b_ref = 2'b00; m_c_ref = 2'b00;
      fa_s = 2'b00; fa_cout = 2'b00; m_tok = 0;
    end else if ((^(fa_a ^ m_a_ref)) === 1'b1 && (^(fa_b ^ m_b_ref)) === 1'b1 &&
                 (^(fa_cin ^ m_c_ref)) === 1'b1) begin
      m_va = (fa_a ^ m_a_ref) == 2'b10;
      m_vb = (fa_b ^ m_b_ref) == 2'b10;
      m_vc = (fa_cin ^ m_c_ref) == 2'b10;
      m_a_ref = fa_a; m_b_ref = fa_b; m_c_ref = fa_cin;
      m_st = (m_va ^ m_vb ^ m_vc) ? 2'b10 : 2'b01;
      m_ct = ((m_va & m_vb) | (m_va & m_vc) | (m_vb & m_vc)) ? 2'b10 : 2'b01;
      if (m_bad_en && m_tok == m_bad_tok) m_st = 2'b11;
      m_tok++;
      if (!m_mute) begin
        m_ds = $urandom_range(1, 20);
        m_dc = $urandom_range(1, 20);
        if (m_ds <= m_dc) begin
          #(m_ds);        fa_s    = fa_s ^ m_st;
          #(m_dc - m_ds); fa_cout = fa_cout ^ m_ct;
        end else begin
          #(m_dc);        fa_cout = fa_cout ^ m_ct;
          #(m_ds - m_dc); fa_s    = fa_s ^ m_st;
        end
      end
    end
  end

  // Monitors: rail toggle and fa_rst-high cycle totals (tests take deltas).
  int   mon_a0 = 0, mon_a1 = 0, mon_rst_hi = 0;
  logic mon_pa0 = 1'b0, mon_pa1 = 1'b0;
  always @(negedge clk) begin
    if (fa_a[0] !== mon_pa0) mon_a0++;
    if (fa_a[1] !== mon_pa1) mon_a1++;
    mon_pa0 = fa_a[0];
    mon_pa1 = fa_a[1];
    if (fa_rst === 1'b1) mon_rst_hi++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input int stall, output logic [7:0] sum, output logic cout,
                       output logic err);
    int n;
    bit busy_bad, hold_bad;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(negedge clk);
    in_valid = 1'b0;
    busy_bad = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 1000) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      out_ready = $urandom_range(0, 1);
      in_valid  = $urandom_range(0, 1);
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (busy_bad) begin
      n_fail++; $display("FAIL busy_in_ready: in_ready seen 1 while busy, required 0");
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL done_wait: out_valid=%b required 1 within 1000 cycles", out_valid);
    end
    sum = out_sum; cout = out_cout; err = out_err;
    hold_bad = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== sum || out_cout !== cout || out_err !== err)
        hold_bad = 1'b1;
    end
    n_checks++;
    if (hold_bad) begin
      n_fail++; $display("FAIL hold: result changed during stall of %0d cycles", stall);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_out: rdy=%b vld=%b sum=%h co=%b err=%b required 1 0 00 0 0",
               in_ready, out_valid, out_sum, out_cout, out_err);
    end
    n_checks++;
    if ({fa_a, fa_b, fa_cin, fa_rst} !== 7'b000000_1) begin
      n_fail++;
      $display("FAIL reset_rails: fa_a=%b fa_b=%b fa_cin=%b fa_rst=%b required 00 00 00 1",
               fa_a, fa_b, fa_cin, fa_rst);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fa_rst !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: fa_rst=%b required 0", fa_rst);
    end
  endtask

  task automatic test_zero();
    logic [7:0] s; logic c, e; int a0, a1;
    a0 = mon_a0; a1 = mon_a1;
    do_op(8'h00, 8'h00, 1'b0, 0, s, c, e);
    n_checks++;
    if ({c, s, e} !== {1'b0, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL zero_sum: cout=%b sum=%h err=%b required 0 00 0", c, s, e);
    end
    n_checks++;
    if (mon_a0 - a0 != 8 || mon_a1 - a1 != 0) begin
      n_fail++;
      $display("FAIL zero_toggles: rail0=%0d rail1=%0d required 8 0", mon_a0 - a0, mon_a1 - a1);
    end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic c, e;
    do_op(8'hFF, 8'h01, 1'b0, 1, s, c, e);
    n_checks++;
    if ({c, s, e} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL carry_ff_01: cout=%b sum=%h err=%b required 1 00 0", c, s, e);
    end
    do_op(8'hA5, 8'h5A, 1'b1, 2, s, c, e);
    n_checks++;
    if ({c, s, e} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL carry_a5_5a: cout=%b sum=%h err=%b required 1 00 0", c, s, e);
    end
    do_op(8'h12, 8'h34, 1'b1, 0, s, c, e);
    n_checks++;
    if ({c, s, e} !== {1'b0, 8'h47, 1'b0}) begin
      n_fail++; $display("FAIL plain_12_34: cout=%b sum=%h err=%b required 0 47 0", c, s, e);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s; logic ci, c, e; logic [8:0] exp;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(ci);
      do_op(a, b, ci, $urandom_range(0, 3), s, c, e);
      n_checks++;
      if ({c, s, e} !== {exp, 1'b0}) begin
        n_fail++;
        $display("FAIL random_%0d: %h+%h+%b got cout=%b sum=%h err=%b required %b %h 0",
                 i, a, b, ci, c, s, e, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] s; logic c, e; int r0;
    m_bad_tok = m_tok + 3;
    m_bad_en  = 1'b1;
    r0 = mon_rst_hi;
    do_op(8'h55, 8'h33, 1'b0, 1, s, c, e);
    m_bad_en = 1'b0;
    n_checks++;
    if ({c, s, e} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL illegal_result: cout=%b sum=%h err=%b required 0 00 1", c, s, e);
    end
    n_checks++;
    if (mon_rst_hi - r0 != 3) begin
      n_fail++; $display("FAIL illegal_flush_len: fa_rst high %0d cycles required 3", mon_rst_hi - r0);
    end
    do_op(8'h03, 8'h04, 1'b0, 0, s, c, e);
    n_checks++;
    if ({c, s, e} !== {1'b0, 8'h07, 1'b0}) begin
      n_fail++; $display("FAIL after_flush: cout=%b sum=%h err=%b required 0 07 0", c, s, e);
    end
  endtask

`ifdef FA_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] s; logic c, e;
    m_mute = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 0, s, c, e);
    m_mute = 1'b0;
    n_checks++;
    if ({c, s, e} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL timeout_result: cout=%b sum=%h err=%b required 0 00 1", c, s, e);
    end
  endtask
`endif

  task automatic test_rst_mid();
    logic [7:0] s; logic c, e; int n, base;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    base = m_tok;
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h3C; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (m_tok < base + 6 && n < 500) begin @(negedge clk); n++; end
    n_checks++;
    if (m_tok < base + 6) begin
      n_fail++; $display("FAIL rst_mid_reach: tokens=%0d required %0d", m_tok - base, 6);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_err, fa_a, fa_b, fa_cin, fa_rst} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000000, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_state: rdy=%b vld=%b sum=%h co=%b err=%b a=%b b=%b ci=%b frst=%b required reset values",
               in_ready, out_valid, out_sum, out_cout, out_err, fa_a, fa_b, fa_cin, fa_rst);
    end
    rst = 1'b0;
    @(negedge clk);
    do_op(8'h10, 8'h20, 1'b0, 0, s, c, e);
    n_checks++;
    if ({c, s, e} !== {1'b0, 8'h30, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_next: cout=%b sum=%h err=%b required 0 30 0", c, s, e);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_illegal();
`ifdef FA_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
